// File: rtl/att_lookup_scheduler.sv
// Address translation table controller for one solver core.
// A load phase streams entries into the table at sequential addresses. A run
// phase shares the table's single registered read port among the lookup
// clients with round-robin arbitration and returns tagged results.
module att_lookup_scheduler #(
  parameter int CLAUSE_COUNT               = 20,
  parameter int LITERAL_ADDRESS_WIDTH      = 12,
  parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11,
  parameter int REQUESTERS                 = 4,
  localparam int ID_W                      = $clog2(REQUESTERS)
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic                                                load_start_i,
  input  logic [LITERAL_ADDRESS_WIDTH:0]                      load_count_i,
  input  logic                                                ld_valid_i,
  output logic                                                ld_ready_o,
  input  logic [CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT-1:0]  ld_data_i,
  output logic                                                load_done_o,
  input  logic [REQUESTERS-1:0]                               req_valid_i,
  input  logic [REQUESTERS*LITERAL_ADDRESS_WIDTH-1:0]         req_addr_i,
  output logic [REQUESTERS-1:0]                               req_ready_o,
  output logic                                                rsp_valid_o,
  output logic [ID_W-1:0]                                     rsp_id_o,
  output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0]               rsp_addr_o,
  output logic [CLAUSE_COUNT-1:0]                             rsp_mask_o,
  output logic                                                tbl_wr_en_o,
  output logic [LITERAL_ADDRESS_WIDTH:0]                      tbl_wr_addr_o,
  output logic [CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT-1:0]  tbl_wr_data_o,
  output logic [LITERAL_ADDRESS_WIDTH-1:0]                    tbl_rd_addr_o,
  input  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0]               tbl_addr_i,
  input  logic [CLAUSE_COUNT-1:0]                             tbl_mask_i
);

  localparam int LAW = LITERAL_ADDRESS_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Table depth and unit increment, both in counter width.
  localparam logic [LAW:0] DEPTH = {1'b1, {LAW{1'b0}}};
  localparam logic [LAW:0] ONE   = {{LAW{1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [LAW:0]    ld_count;
  logic [LAW:0]    wr_cnt;
  logic [LAW:0]    wr_next;
  logic [LAW:0]    start_count;
  logic            start_ok;
  logic            accept;

  logic [ID_W-1:0] ptr;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic [LAW-1:0]  gnt_addr;
  logic [ID_W-1:0] cand;
  int              idx;

  logic [LAW-1:0]  rd_addr_p0;
  logic            rsp_vld_p1;
  logic [ID_W-1:0] rsp_id_p1;

  // A start is only meaningful outside LOAD; the requested count is clamped
  // to the table depth so the counter never runs past the last address.
  assign start_ok    = load_start_i && ((state == ST_IDLE) || (state == ST_RUN));
  assign start_count = (load_count_i > DEPTH) ? DEPTH : load_count_i;

  // Write port is driven combinationally so each beat lands at its accept edge.
  assign ld_ready_o    = (state == ST_LOAD);
  assign accept        = ld_ready_o && ld_valid_i && (wr_cnt != ld_count);
  assign wr_next       = wr_cnt + ONE;
  assign tbl_wr_en_o   = accept;
  assign tbl_wr_addr_o = wr_cnt;
  assign tbl_wr_data_o = ld_data_i;
  assign load_done_o   = (state == ST_RUN);

  // Load/run phase sequencing and the sequential write counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      ld_count <= '0;
      wr_cnt   <= '0;
    end else if (start_ok) begin
      state    <= ST_LOAD;
      ld_count <= start_count;
      wr_cnt   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (wr_cnt == ld_count) begin
            state <= ST_RUN;
          end else if (accept) begin
            wr_cnt <= wr_next;
            if (wr_next == ld_count) begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN:  state <= ST_RUN;
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Round-robin pick: first valid requester at or after ptr+1. A reload
  // request or reset in the same cycle suppresses the grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    idx     = 0;
    if ((state == ST_RUN) && !load_start_i && !rst_i) begin
      for (int k = 0; k < REQUESTERS; k++) begin
        idx  = (int'(ptr) + 1 + k) % REQUESTERS;
        cand = ID_W'(idx);
        if (!gnt_vld && req_valid_i[cand]) begin
          gnt_vld = 1'b1;
          gnt_id  = cand;
        end
      end
    end
  end

  // One-hot grant and the granted requester's literal.
  always_comb begin
    req_ready_o = '0;
    gnt_addr    = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (gnt_vld && (gnt_id == ID_W'(k))) begin
        req_ready_o[k] = 1'b1;
        gnt_addr       = req_addr_i[k*LAW +: LAW];
      end
    end
  end

  assign tbl_rd_addr_o = gnt_vld ? gnt_addr : rd_addr_p0;

  // Grant stage -> response stage: the table answers one cycle later, so the
  // ID and valid ride one register alongside it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr        <= ID_W'(REQUESTERS - 1);
      rd_addr_p0 <= '0;
      rsp_vld_p1 <= 1'b0;
      rsp_id_p1  <= '0;
    end else begin
      rsp_vld_p1 <= gnt_vld;
      if (gnt_vld) begin
        ptr        <= gnt_id;
        rd_addr_p0 <= gnt_addr;
        rsp_id_p1  <= gnt_id;
      end
    end
  end

  assign rsp_valid_o = rsp_vld_p1;
  assign rsp_id_o    = rsp_id_p1;
  assign rsp_addr_o  = tbl_addr_i;
  assign rsp_mask_o  = tbl_mask_i;

endmodule

// File: tb/tb_att_lookup_scheduler.sv
// Bench for att_lookup_scheduler: models the registered table, loads it,
// then checks arbitration order and tagged responses via a scoreboard queue.
module tb_att_lookup_scheduler;

  localparam int CC   = 20;
  localparam int LAW  = 12;
  localparam int CAW  = 11;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int EW   = CAW + CC;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [LAW:0]      load_count;
  logic              ld_valid;
  logic              ld_ready;
  logic [EW-1:0]     ld_data;
  logic              load_done;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*LAW-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [CAW-1:0]    rsp_addr;
  logic [CC-1:0]     rsp_mask;
  logic              tbl_wr_en;
  logic [LAW:0]      tbl_wr_addr;
  logic [EW-1:0]     tbl_wr_data;
  logic [LAW-1:0]    tbl_rd_addr;
  logic [EW-1:0]     tbl_q;

  always #5 clk = ~clk;

  att_lookup_scheduler #(
    .CLAUSE_COUNT(CC), .LITERAL_ADDRESS_WIDTH(LAW),
    .CLAUSE_TABLE_ADDRESS_WIDTH(CAW), .REQUESTERS(NREQ)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .load_start_i(load_start), .load_count_i(load_count),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_data_i(ld_data),
    .load_done_o(load_done),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id),
    .rsp_addr_o(rsp_addr), .rsp_mask_o(rsp_mask),
    .tbl_wr_en_o(tbl_wr_en), .tbl_wr_addr_o(tbl_wr_addr), .tbl_wr_data_o(tbl_wr_data),
    .tbl_rd_addr_o(tbl_rd_addr),
    .tbl_addr_i(tbl_q[EW-1:CC]), .tbl_mask_i(tbl_q[CC-1:0])
  );

  // Table instance model: write and registered read.
  logic [EW-1:0] mem [0:(1<<LAW)-1];
  always @(posedge clk) begin
    if (tbl_wr_en) mem[tbl_wr_addr[LAW-1:0]] <= tbl_wr_data;
    tbl_q <= mem[tbl_rd_addr];
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic [EW-1:0]  data;
  } rsp_t;
  rsp_t exp_q[$];

  typedef struct {
    logic [NREQ-1:0]     rv;
    logic [NREQ*LAW-1:0] ad;
    logic [NREQ-1:0]     er;
  } vec_t;
  vec_t vt[18];

  int vec_n = 0;
  int err_n = 0;
  logic [LAW-1:0] last_rd = '0;

  localparam logic [NREQ*LAW-1:0] DA = {12'd3, 12'd2, 12'd1, 12'd0};
  localparam logic [NREQ*LAW-1:0] DB = {12'd0, 12'd1, 12'd2, 12'd3};

  function automatic logic [EW-1:0] entry(input logic [LAW-1:0] a);
    logic [CAW-1:0] hi;
    hi = a[CAW-1:0] + 11'h0A0;
    return {hi, 8'hCA, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check just after; st is the expected state
  // during the cycle (0 idle, 1 load, 2 run).
  task automatic cyc(input logic r, input logic [NREQ-1:0] rv, input logic [NREQ*LAW-1:0] ad,
                     input logic ls, input logic [LAW:0] lc, input logic lv, input logic [EW-1:0] ld,
                     input logic [NREQ-1:0] er, input logic ew, input logic [LAW:0] ewa,
                     input int st);
    rsp_t e;
    int   g;
    @(negedge clk);
    rst = r; req_valid = rv; req_addr = ad; load_start = ls; load_count = lc;
    ld_valid = lv; ld_data = ld;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_data", {rsp_addr, rsp_mask}, e.data);
    end else begin
      chk("rsp_valid_quiet", rsp_valid, 1'b0);
    end
    chk("req_ready", req_ready, er);
    g = -1;
    for (int i = 0; i < NREQ; i++) if (er[i]) g = i;
    if (g >= 0) begin
      chk("rd_addr", tbl_rd_addr, ad[g*LAW +: LAW]);
      last_rd = ad[g*LAW +: LAW];
      e.id   = g[IDW-1:0];
      e.data = entry(ad[g*LAW +: LAW]);
      exp_q.push_back(e);
    end else begin
      chk("rd_addr_hold", tbl_rd_addr, last_rd);
    end
    chk("wr_en", tbl_wr_en, ew);
    if (ew) begin
      chk("wr_addr", tbl_wr_addr, ewa);
      chk("wr_data", tbl_wr_data, ld);
    end
    chk("load_done", load_done, st == 2);
    chk("ld_ready", ld_ready, st == 1);
    if (r) begin
      exp_q.delete();
      last_rd = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << LAW); i++) mem[i] = '0;
    vt[0]  = '{4'b0100, {12'd0, 12'd3, 12'd0, 12'd0}, 4'b0100};
    vt[1]  = '{4'b0000, DA, 4'b0000};
    vt[2]  = '{4'b1000, DA, 4'b1000};
    vt[3]  = '{4'b1111, DA, 4'b0001};
    vt[4]  = '{4'b1111, DB, 4'b0010};
    vt[5]  = '{4'b1111, DA, 4'b0100};
    vt[6]  = '{4'b1111, DB, 4'b1000};
    vt[7]  = '{4'b1111, DB, 4'b0001};
    vt[8]  = '{4'b1111, DA, 4'b0010};
    vt[9]  = '{4'b1111, DB, 4'b0100};
    vt[10] = '{4'b1111, DA, 4'b1000};
    vt[11] = '{4'b0010, DA, 4'b0010};
    vt[12] = '{4'b1010, DA, 4'b1000};
    vt[13] = '{4'b1010, DB, 4'b0010};
    vt[14] = '{4'b1010, DA, 4'b1000};
    vt[15] = '{4'b0101, DA, 4'b0001};
    vt[16] = '{4'b0101, DB, 4'b0100};
    vt[17] = '{4'b0000, DA, 4'b0000};

    rst = 1'b1; load_start = 1'b0; load_count = '0; ld_valid = 1'b0; ld_data = '0;
    req_valid = '0; req_addr = '0;
    repeat (2) @(posedge clk);

    // Reset state; requests ignored in IDLE.
    cyc(0, 4'b1111, DA, 0, 0, 0, '0, 4'b0000, 0, 0, 0);
    chk("rsp_id_reset", rsp_id, 2'd0);

    // Load 4 entries with one idle beat in the middle.
    cyc(0, 4'b0000, DA, 1, 13'd4, 0, '0, 4'b0000, 0, 0, 0);
    cyc(0, 4'b1111, DA, 0, 0, 1, entry(12'd0), 4'b0000, 1, 13'd0, 1);
    cyc(0, 4'b0000, DA, 1, 0, 1, entry(12'd1), 4'b0000, 1, 13'd1, 1);
    cyc(0, 4'b0000, DA, 0, 0, 0, entry(12'd9), 4'b0000, 0, 0, 1);
    cyc(0, 4'b0000, DA, 0, 0, 1, entry(12'd2), 4'b0000, 1, 13'd2, 1);
    cyc(0, 4'b0000, DA, 0, 0, 1, entry(12'd3), 4'b0000, 1, 13'd3, 1);

    // Arbitration vectors (pointer starts at requester 3).
    for (int i = 0; i < 18; i++)
      cyc(0, vt[i].rv, vt[i].ad, 0, 0, 0, '0, vt[i].er, 0, 0, 2);

    // Reload during RUN with requests pending; zero-count load.
    cyc(0, 4'b1111, DA, 0, 0, 0, '0, 4'b1000, 0, 0, 2);
    cyc(0, 4'b1111, DA, 1, 13'd0, 0, '0, 4'b0000, 0, 0, 2);
    cyc(0, 4'b1111, DA, 0, 0, 1, entry(12'd7), 4'b0000, 0, 0, 1);
    cyc(0, 4'b1111, DB, 0, 0, 0, '0, 4'b0001, 0, 0, 2);

    // Reset the cycle after a grant.
    cyc(0, 4'b0010, DA, 0, 0, 0, '0, 4'b0010, 0, 0, 2);
    cyc(1, 4'b1111, DA, 0, 0, 0, '0, 4'b0000, 0, 0, 2);
    cyc(0, 4'b1111, DA, 0, 0, 0, '0, 4'b0000, 0, 0, 0);
    cyc(0, 4'b1111, DA, 0, 0, 0, '0, 4'b0000, 0, 0, 0);
    chk("rsp_id_after_rst", rsp_id, 2'd0);

    // Oversized count clamps to the full table depth.
    cyc(0, 4'b0000, DA, 1, 13'h1FFF, 0, '0, 4'b0000, 0, 0, 0);
    for (int i = 0; i < (1 << LAW); i++)
      cyc(0, 4'b0001, DA, 0, 0, 1, entry(i[LAW-1:0]), 4'b0000, 1, i[LAW:0], 1);
    cyc(0, 4'b0001, {12'd0, 12'd0, 12'd0, 12'd4095}, 0, 0, 1, '0, 4'b0001, 0, 0, 2);
    cyc(0, 4'b0011, {12'd0, 12'd0, 12'd2048, 12'd0}, 0, 0, 0, '0, 4'b0010, 0, 0, 2);
    cyc(0, 4'b0000, DA, 0, 0, 0, '0, 4'b0000, 0, 0, 2);
    cyc(0, 4'b0000, DA, 0, 0, 0, '0, 4'b0000, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
